axi_write_responder: RTL

Slave-side AXI write channel engine for the on-chip slaves (IM, DM, DRAM wrapper front end). It accepts one write address, consumes the matching write-data burst, and issues byte-enabled word writes to a single-port memory. It then returns exactly one write response carrying the full interconnect ID. It is the B-channel source that the interconnect's write-response arbiter collects from each slave port.

---
 rtl/axi_write_responder.sv | 101 ++++++++++
 1 files changed

// File: rtl/axi_write_responder.sv
// AXI write slave engine: one AW, its W burst as byte-enabled word writes, one B.
// state | meaning: IDLE = accept AW, DATA = consume W beats, RESP = hold B until BREADY
module axi_write_responder #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   AWID_S,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID_S,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_a,
  output logic [DATA_W-1:0] mem_di
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ID_W-1:0]   r_id;
  logic [MEM_AW-1:0] r_base;
  logic [3:0]        r_len;
  logic [3:0]        r_beat;
  logic              r_err;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_unused;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (AWVALID)         w_next = S_DATA;
      S_DATA:  if (WVALID && WLAST) w_next = S_RESP;
      S_RESP:  if (BREADY)          w_next = S_IDLE;
      default:                      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = (r_state == S_IDLE);
    WREADY  = (r_state == S_DATA);
    BVALID  = (r_state == S_RESP);
    BRESP   = (r_state == S_RESP && r_err) ? 2'b10 : 2'b00;
  end

  assign w_aw_hs = AWVALID && AWREADY;
  assign w_w_hs  = WVALID && WREADY;

  // WLAST must coincide exactly with beat==len; any disagreement poisons the burst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id   <= '0;
      r_base <= '0;
      r_len  <= '0;
      r_beat <= '0;
      r_err  <= 1'b0;
    end else if (w_aw_hs) begin
      r_id   <= AWID_S;
      r_base <= AWADDR[MEM_AW+1:2];
      r_len  <= AWLEN;
      r_beat <= '0;
      r_err  <= (AWSIZE != 3'b010) || (AWBURST != 2'b01);
    end else if (w_w_hs) begin
      if (r_beat != 4'hF) r_beat <= r_beat + 4'd1;
      if (WLAST != (r_beat == r_len)) r_err <= 1'b1;
    end
  end

  assign BID_S  = r_id;
  assign mem_we = (w_w_hs && !r_err) ? WSTRB : 4'b0000;
  assign mem_a  = r_base + MEM_AW'(r_beat);
  assign mem_di = WDATA;

  assign w_unused = ^{AWADDR[ADDR_W-1:MEM_AW+2], AWADDR[1:0]};

endmodule
